control_unit: RTL and testbench

- Multicycle control FSM for the Mary/Shelley accumulator-and-stack CPU.
- Sequences FETCH, DECODE, EXECUTE and optional WRITEBACK.
- Drives every datapath write-enable and mux select from the current state plus OPCODE and flagbit. OPCODE and flagbit come from the externally held instruction register.
- flagbit selects the alternate operand or destination: Shelley or register operand instead of Mary or immediate.

---
 rtl/control_pkg.sv | 26 ++
 rtl/control_unit.sv | 117 +++++++++++
 tb/tb_control_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// control_pkg: state, opcode and datapath select encodings for the Mary/Shelley control unit.
package control_pkg;
  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} state_t;
  localparam logic [4:0] OP_APUT = 5'd0;
  localparam logic [4:0] OP_SPUT = 5'd1;
  localparam logic [4:0] OP_AADD = 5'd2;
  localparam logic [4:0] OP_ASUB = 5'd3;
  localparam logic [4:0] OP_SPEK = 5'd4;
  localparam logic [4:0] OP_SPOP = 5'd5;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [1:0] MARY_MEM = 2'b00;
  localparam logic [1:0] MARY_ALU = 2'b01;
  localparam logic [1:0] MARY_IMM = 2'b11;
  localparam logic [1:0] SHEL_MEM = 2'b00;
  localparam logic [1:0] SHEL_IMM = 2'b01;
  localparam logic [1:0] SP_DEC = 2'b01;
  localparam logic [1:0] SP_INC = 2'b10;
  localparam logic [2:0] MEM_PC = 3'b000;
  localparam logic [2:0] MEM_PUSH = 3'b100;
  localparam logic [2:0] MEM_PEEK = 3'b101;
  localparam logic [2:0] MEM_POP = 3'b110;
  localparam logic [2:0] PC_INC = 3'b000;
  localparam logic [2:0] MSRC_MARY = 3'b000;
  localparam logic [2:0] MSRC_SHELLEY = 3'b001;
endpackage

// File: rtl/control_unit.sv
// control_unit: multicycle FETCH/DECODE/EXECUTE/WRITEBACK controller with Mealy datapath controls.
import control_pkg::*;

module control_unit (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [4:0] OPCODE,
  input  logic       flagbit,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [2:0] MemSrc,
  output logic       RegWrite,
  output logic       MaryWrite,
  output logic       ShelleyWrite,
  output logic       CompWrite,
  output logic       RAWrite,
  output logic       PCWrite,
  output logic       SPWrite,
  output logic [1:0] MarySrc,
  output logic [1:0] ShelleySrc,
  output logic       RASrc,
  output logic [2:0] PCSrc,
  output logic [1:0] SPSrc,
  output logic       RegDst,
  output logic [2:0] MemDst,
  output logic       RegData,
  output logic       SrcA,
  output logic       SrcB,
  output logic [3:0] ALUOP
);
  state_t r_state;
  logic   w_long;

  assign w_long = OPCODE inside {OP_AADD, OP_ASUB, OP_SPEK, OP_SPOP};

  always_ff @(posedge CLK) begin
    if (!Reset) r_state <= FETCH;
    else case (r_state)
      FETCH:   r_state <= DECODE;
      DECODE:  r_state <= EXECUTE;
      EXECUTE: r_state <= w_long ? WRITEBACK : FETCH;
      default: r_state <= FETCH;
    endcase
  end

  // Outputs are forced to 0 while Reset is held low, independent of the state register.
  always_comb begin
    MemRead = 1'b0;
    MemWrite = 1'b0;
    MemSrc = MSRC_MARY;
    RegWrite = 1'b0;
    MaryWrite = 1'b0;
    ShelleyWrite = 1'b0;
    CompWrite = 1'b0;
    RAWrite = 1'b0;
    PCWrite = 1'b0;
    SPWrite = 1'b0;
    MarySrc = 2'b00;
    ShelleySrc = 2'b00;
    RASrc = 1'b0;
    PCSrc = PC_INC;
    SPSrc = 2'b00;
    RegDst = 1'b0;
    MemDst = MEM_PC;
    RegData = 1'b0;
    SrcA = 1'b0;
    SrcB = 1'b0;
    ALUOP = 4'b0000;
    if (Reset) case (r_state)
      FETCH: begin
        MemRead = 1'b1;
        RegWrite = 1'b1;
        PCWrite = 1'b1;
      end
      EXECUTE: case (OPCODE)
        OP_APUT: begin
          MaryWrite = !flagbit;
          MarySrc = flagbit ? 2'b00 : MARY_IMM;
          ShelleyWrite = flagbit;
          ShelleySrc = flagbit ? SHEL_IMM : 2'b00;
        end
        OP_SPUT: begin
          MemWrite = 1'b1;
          MemDst = MEM_PUSH;
          MemSrc = flagbit ? MSRC_SHELLEY : MSRC_MARY;
          SPWrite = 1'b1;
          SPSrc = SP_DEC;
        end
        OP_AADD, OP_ASUB: begin
          SrcB = !flagbit;
          ALUOP = (OPCODE == OP_AADD) ? ALU_ADD : ALU_SUB;
        end
        OP_SPEK, OP_SPOP: begin
          MemRead = 1'b1;
          MemDst = (OPCODE == OP_SPEK) ? MEM_PEEK : MEM_POP;
        end
        default: ;
      endcase
      WRITEBACK: case (OPCODE)
        OP_AADD, OP_ASUB: begin
          MaryWrite = 1'b1;
          MarySrc = MARY_ALU;
        end
        OP_SPEK, OP_SPOP: begin
          MaryWrite = !flagbit;
          MarySrc = MARY_MEM;
          ShelleyWrite = flagbit;
          ShelleySrc = SHEL_MEM;
          SPWrite = (OPCODE == OP_SPOP);
          SPSrc = (OPCODE == OP_SPOP) ? SP_INC : 2'b00;
        end
        default: ;
      endcase
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed scoreboard bench for the control_unit FSM and its Mealy outputs.
module tb_control_unit;
  typedef struct packed {
    logic mem_read, mem_write;
    logic [2:0] mem_src;
    logic reg_write, mary_write, shelley_write, comp_write, ra_write, pc_write, sp_write;
    logic [1:0] mary_src, shelley_src;
    logic ra_src;
    logic [2:0] pc_src;
    logic [1:0] sp_src;
    logic reg_dst;
    logic [2:0] mem_dst;
    logic reg_data, src_a, src_b;
    logic [3:0] alu_op;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] opcode;
  logic flag;
  out_t obs;
  out_t e;
  out_t q[$];
  string tq[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .CLK(clk), .Reset(rst_n), .OPCODE(opcode), .flagbit(flag),
    .MemRead(obs.mem_read), .MemWrite(obs.mem_write), .MemSrc(obs.mem_src),
    .RegWrite(obs.reg_write), .MaryWrite(obs.mary_write), .ShelleyWrite(obs.shelley_write),
    .CompWrite(obs.comp_write), .RAWrite(obs.ra_write), .PCWrite(obs.pc_write),
    .SPWrite(obs.sp_write), .MarySrc(obs.mary_src), .ShelleySrc(obs.shelley_src),
    .RASrc(obs.ra_src), .PCSrc(obs.pc_src), .SPSrc(obs.sp_src), .RegDst(obs.reg_dst),
    .MemDst(obs.mem_dst), .RegData(obs.reg_data), .SrcA(obs.src_a), .SrcB(obs.src_b),
    .ALUOP(obs.alu_op)
  );

  task automatic chk(input string tag, input out_t exp_v);
    out_t x;
    string t;
    q.push_back(exp_v);
    tq.push_back(tag);
    #1;
    x = q.pop_front();
    t = tq.pop_front();
    checks++;
    assert (obs === x) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, x);
    end
  endtask

  task automatic fetch_decode(input logic [4:0] op, input logic f, input string tag);
    out_t fe;
    opcode = op;
    flag = f;
    fe = '0;
    fe.mem_read = 1'b1;
    fe.reg_write = 1'b1;
    fe.pc_write = 1'b1;
    chk({tag, "_fetch"}, fe);
    @(negedge clk);
    chk({tag, "_decode"}, '0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 5'd0;
    flag = 1'b0;
    @(negedge clk);
    chk("rst_low", '0);
    rst_n = 1'b1;
    fetch_decode(5'd0, 1'b0, "aput");
    e = '0; e.mary_write = 1'b1; e.mary_src = 2'b11;
    chk("aput_f0_exec", e);
    flag = 1'b1;
    e = '0; e.shelley_write = 1'b1; e.shelley_src = 2'b01;
    chk("aput_f1_exec", e);
    @(negedge clk);
    fetch_decode(5'd1, 1'b1, "sput");
    e = '0; e.mem_write = 1'b1; e.mem_dst = 3'b100; e.mem_src = 3'b001;
    e.sp_write = 1'b1; e.sp_src = 2'b01;
    chk("sput_exec", e);
    @(negedge clk);
    fetch_decode(5'd2, 1'b0, "aadd");
    e = '0; e.src_b = 1'b1; e.alu_op = 4'b0010;
    chk("aadd_exec", e);
    @(negedge clk);
    e = '0; e.mary_write = 1'b1; e.mary_src = 2'b01;
    chk("aadd_wb", e);
    @(negedge clk);
    fetch_decode(5'd3, 1'b1, "asub");
    e = '0; e.alu_op = 4'b0011;
    chk("asub_exec", e);
    @(negedge clk);
    e = '0; e.mary_write = 1'b1; e.mary_src = 2'b01;
    chk("asub_wb", e);
    @(negedge clk);
    fetch_decode(5'd4, 1'b1, "spek");
    e = '0; e.mem_read = 1'b1; e.mem_dst = 3'b101;
    chk("spek_exec", e);
    @(negedge clk);
    e = '0; e.shelley_write = 1'b1; e.shelley_src = 2'b00;
    chk("spek_wb", e);
    @(negedge clk);
    fetch_decode(5'd5, 1'b0, "spop");
    e = '0; e.mem_read = 1'b1; e.mem_dst = 3'b110;
    chk("spop_exec", e);
    @(negedge clk);
    e = '0; e.mary_write = 1'b1; e.sp_write = 1'b1; e.sp_src = 2'b10;
    chk("spop_wb", e);
    rst_n = 1'b0;
    chk("rst_in_wb", '0);
    @(negedge clk);
    chk("rst_held", '0);
    rst_n = 1'b1;
    fetch_decode(5'd7, 1'b1, "nop7");
    chk("nop7_exec", '0);
    @(negedge clk);
    fetch_decode(5'd31, 1'b0, "nop31");
    chk("nop31_exec", '0);
    @(negedge clk);
    fetch_decode(5'd0, 1'b0, "after_nop");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
